// File: rtl/pc_unit_if.sv
// Bus between the fetch-stage control logic and the program-counter unit.
// The master drives the control requests; the slave (pc_unit) returns the
// fetch address, its successor, the saved exception PC and status.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             exception;
    logic             eret;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_inc;
    logic [WIDTH-1:0] epc;
    logic             pc_valid;
    logic [1:0]       state;

    modport master (
        output en, branch_taken, branch_target, jump, jump_target,
               exception, eret, halt, resume,
        input  pc, pc_plus_inc, epc, pc_valid, state
    );

    modport slave (
        input  en, branch_taken, branch_target, jump, jump_target,
               exception, eret, halt, resume,
        output pc, pc_plus_inc, epc, pc_valid, state
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage: prioritised next-PC
// selection, stall, exception entry/return with EPC, and a BOOT/RUN/HALTED
// state machine that gates pc_valid.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int               INC          = 4,
    parameter int               ALIGN_BITS   = 2,
    parameter int               BOOT_CYCLES  = 2
) (
    input logic      clk,
    input logic      reset,
    pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam int               CNT_W      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int               BOOT_LAST  = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));
    // With no boot delay the unit leaves reset straight into RUN.
    localparam state_e           RST_STATE  = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic             valid_q, valid_d;

    // Next-state selection: state machine plus prioritised next-PC mux.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        pc_d    = pc_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        state_d = state_q;

        unique case (state_q)
            ST_BOOT: begin
                // Control inputs are ignored; pc stays on the reset vector.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BOOT_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.exception) begin
                    // Trap entry ignores the stall; epc captures the faulting pc.
                    pc_d  = EXC_VECTOR;
                    epc_d = pc_q;
                end else if (bus.en) begin
                    if (bus.eret) begin
                        pc_d = epc_q;
                    end else if (bus.jump) begin
                        pc_d = bus.jump_target & ALIGN_MASK;
                    end else if (bus.branch_taken) begin
                        pc_d = bus.branch_target & ALIGN_MASK;
                    end else begin
                        pc_d = pc_q + WIDTH'(INC);
                    end
                    // The pc update of the halting cycle still takes effect.
                    if (bus.halt) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.exception) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc_q;
                    state_d = ST_RUN;
                end else if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        valid_d = (state_d == ST_RUN);
    end

    // State register; synchronous reset dominates every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RST_STATE;
            valid_q <= (BOOT_CYCLES == 0);
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pc_q + WIDTH'(INC);
    assign bus.epc         = epc_q;
    assign bus.pc_valid    = valid_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with default parameters: boot sequence,
// stall, jump/branch priority and alignment, exception entry/return, wrap,
// halt/resume and reset from HALTED.
module tb_pc_unit;

    localparam logic [1:0] BOOT   = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] HALTED = 2'b10;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0080),
        .INC         (4),
        .ALIGN_BITS  (2),
        .BOOT_CYCLES (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock edge; returns on the following falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctrl();
        bus.en            = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.exception     = 1'b0;
        bus.eret          = 1'b0;
        bus.halt          = 1'b0;
        bus.resume        = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] pc,
                                input logic [1:0] st, input logic valid);
        check({tag, ".pc"}, bus.pc, pc);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".valid"}, 32'(bus.pc_valid), 32'(valid));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_ctrl();
        @(negedge clk);
        tick();

        // Reset state.
        check_status("reset", 32'h0, BOOT, 1'b0);
        check("reset.epc", bus.epc, 32'h0);

        // BOOT ignores control inputs, including an exception request.
        reset             = 1'b0;
        bus.en            = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        bus.exception     = 1'b1;
        tick();
        check_status("boot1", 32'h0, BOOT, 1'b0);
        check("boot1.epc", bus.epc, 32'h0);
        tick();
        check_status("boot2", 32'h0, RUN, 1'b1);

        // Sequential fetch.
        clear_ctrl();
        bus.en = 1'b1;
        tick();
        check("seq.pc4", bus.pc, 32'h4);
        tick();
        check("seq.pc8", bus.pc, 32'h8);
        tick();
        check("seq.pcC", bus.pc, 32'hC);
        check("seq.pc_plus_inc", bus.pc_plus_inc, 32'h10);
        tick();
        check("seq.pc10", bus.pc, 32'h10);

        // Stall for three cycles.
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.pc", bus.pc, 32'h10);
        end

        // Jump beats branch; low target bits are cleared.
        bus.en            = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h103;
        tick();
        check("jump_vs_branch.pc", bus.pc, 32'h100);
        check("jump_vs_branch.pc_plus_inc", bus.pc_plus_inc, 32'h104);

        // Branch alone, with an unaligned target.
        bus.jump          = 1'b0;
        bus.branch_target = 32'h26;
        tick();
        check("branch.pc", bus.pc, 32'h24);

        // Exception while stalled.
        clear_ctrl();
        bus.exception = 1'b1;
        tick();
        check("exc.pc", bus.pc, 32'h80);
        check("exc.epc", bus.epc, 32'h24);

        // Return from exception.
        clear_ctrl();
        bus.en   = 1'b1;
        bus.eret = 1'b1;
        tick();
        check("eret.pc", bus.pc, 32'h24);

        // eret requires en.
        bus.en          = 1'b0;
        bus.jump_target = 32'h30;
        bus.jump        = 1'b1;
        tick();
        check("eret_stalled.pc", bus.pc, 32'h24);

        // Move to 0x30, then exception and eret together.
        bus.eret = 1'b0;
        bus.en   = 1'b1;
        tick();
        check("jump30.pc", bus.pc, 32'h30);
        clear_ctrl();
        bus.en        = 1'b1;
        bus.exception = 1'b1;
        bus.eret      = 1'b1;
        tick();
        check("exc_eret.pc", bus.pc, 32'h80);
        check("exc_eret.epc", bus.epc, 32'h30);

        // Wrap past all-ones.
        clear_ctrl();
        bus.en          = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_target = 32'hFFFF_FFFC;
        tick();
        check("wrap_pre.pc", bus.pc, 32'hFFFF_FFFC);
        check("wrap_pre.pc_plus_inc", bus.pc_plus_inc, 32'h0);
        bus.jump = 1'b0;
        tick();
        check("wrap.pc", bus.pc, 32'h0);
        check("wrap.pc_plus_inc", bus.pc_plus_inc, 32'h4);

        // Go to 0x50; halt without en is ignored.
        bus.jump        = 1'b1;
        bus.jump_target = 32'h50;
        tick();
        clear_ctrl();
        bus.halt = 1'b1;
        tick();
        check_status("halt_stalled", 32'h50, RUN, 1'b1);

        // Halt at 0x50: the advance still happens.
        bus.en = 1'b1;
        tick();
        check_status("halt", 32'h54, HALTED, 1'b0);

        // Control inputs ignored while halted.
        clear_ctrl();
        bus.en            = 1'b1;
        bus.halt          = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h200;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h300;
        bus.eret          = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_status("halted_ignore", 32'h54, HALTED, 1'b0);
        end

        // Resume.
        clear_ctrl();
        bus.resume = 1'b1;
        tick();
        check_status("resume", 32'h54, RUN, 1'b1);

        // Halt together with a branch back to 0x54.
        clear_ctrl();
        bus.en            = 1'b1;
        bus.halt          = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h54;
        tick();
        check_status("halt_branch", 32'h54, HALTED, 1'b0);

        // Exception with resume while halted: exception wins.
        clear_ctrl();
        bus.exception = 1'b1;
        bus.resume    = 1'b1;
        tick();
        check_status("halted_exc", 32'h80, RUN, 1'b1);
        check("halted_exc.epc", bus.epc, 32'h54);

        // Build epc=0x24, halt, then reset from HALTED.
        clear_ctrl();
        bus.en          = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_target = 32'h24;
        tick();
        clear_ctrl();
        bus.exception = 1'b1;
        tick();
        check("pre_reset.epc", bus.epc, 32'h24);
        clear_ctrl();
        bus.en   = 1'b1;
        bus.halt = 1'b1;
        tick();
        check_status("pre_reset", 32'h84, HALTED, 1'b0);
        reset = 1'b1;
        tick();
        check_status("mid_reset", 32'h0, BOOT, 1'b0);
        check("mid_reset.epc", bus.epc, 32'h0);

        reset = 1'b0;
        clear_ctrl();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
